// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared types and constants for the switch debouncer
package debounce_pkg;

    // Debounce FSM state encoding
    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        S_LH   = 2'd1,
        S_HIGH = 2'd2,
        S_HL   = 2'd3
    } deb_state_t;

    // Width of the optional abort (glitch) counter
    localparam int GLITCH_W = 8;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous bit
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1;

    // Two-stage capture; only q is safe to use in the clk domain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/switch_debounce_sync.sv
// rtl/switch_debounce_sync.sv - switch debouncer with edge strobes; optional DEBOUNCE_GLITCH_CNT_EN adds glitch_cnt
module switch_debounce_sync
    import debounce_pkg::*;
#(
    parameter int CNT_W         = 8,
    parameter int STABLE_CYCLES = 200
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                din_raw,
    output logic                dout,
    output logic                rise,
    output logic                fall,
    output logic                busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

    // Terminal count: a candidate level must be seen STABLE_CYCLES times
    localparam logic [CNT_W-1:0] TERM = CNT_W'(STABLE_CYCLES - 1);

    generate
        if (STABLE_CYCLES < 1 || STABLE_CYCLES > (2 ** CNT_W)) begin : g_bad_cfg
            $error("STABLE_CYCLES out of range 1..2**CNT_W");
        end
    endgenerate

    logic             s2;
    deb_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             dout_nxt, rise_nxt, fall_nxt, busy_nxt;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (din_raw),
        .q   (s2)
    );

    // Next-state logic; the terminal compare precedes the increment so cnt never wraps
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dout_nxt  = dout;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        case (state)
            S_LOW: begin
                if (s2) begin
                    state_nxt = S_LH;
                    cnt_nxt   = '0;
                end
            end
            S_LH: begin
                if (!s2) begin
                    state_nxt = S_LOW;
                end else if (cnt == TERM) begin
                    state_nxt = S_HIGH;
                    dout_nxt  = 1'b1;
                    rise_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_HIGH: begin
                if (!s2) begin
                    state_nxt = S_HL;
                    cnt_nxt   = '0;
                end
            end
            S_HL: begin
                if (s2) begin
                    state_nxt = S_HIGH;
                end else if (cnt == TERM) begin
                    state_nxt = S_LOW;
                    dout_nxt  = 1'b0;
                    fall_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = S_LOW;
            end
        endcase
        busy_nxt = (state_nxt == S_LH) || (state_nxt == S_HL);
    end

    // State, counter and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_LOW;
            cnt   <= '0;
            dout  <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            dout  <= dout_nxt;
            rise  <= rise_nxt;
            fall  <= fall_nxt;
            busy  <= busy_nxt;
        end
    end

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic abort;

    // A qualification cut short by a return to the settled level is a glitch
    always_comb begin
        abort = ((state == S_LH) && !s2) || ((state == S_HL) && s2);
    end

    // Saturating glitch counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            glitch_cnt <= '0;
        end else if (abort && (glitch_cnt != {GLITCH_W{1'b1}})) begin
            glitch_cnt <= glitch_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_switch_debounce_sync.sv
// tb/tb_switch_debounce_sync.sv - self-checking bench for switch_debounce_sync
module tb_switch_debounce_sync;

    localparam int STABLE = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       din_raw = 1'b1;
    logic       dout, rise, fall, busy;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    switch_debounce_sync #(.CNT_W(8), .STABLE_CYCLES(STABLE)) dut (
        .clk        (clk),
        .rst        (rst),
        .din_raw    (din_raw),
        .dout       (dout),
        .rise       (rise),
        .fall       (fall),
        .busy       (busy)
`ifdef DEBOUNCE_GLITCH_CNT_EN
        ,
        .glitch_cnt (glitch_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: input reaches the deciding logic two edges late; the output flips once
    // STABLE+1 consecutive samples differ from it; a broken run counts as a glitch
    logic m_p1, m_p2, m_dout, m_rise, m_fall;
    int   m_run, m_glitch;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_p1 <= 1'b0; m_p2 <= 1'b0; m_dout <= 1'b0;
            m_rise <= 1'b0; m_fall <= 1'b0; m_run <= 0; m_glitch <= 0;
        end else begin
            m_p1 <= din_raw;
            m_p2 <= m_p1;
            m_rise <= 1'b0;
            m_fall <= 1'b0;
            if (m_p2 != m_dout) begin
                if (m_run == STABLE) begin
                    m_dout <= m_p2;
                    m_rise <= m_p2;
                    m_fall <= !m_p2;
                    m_run  <= 0;
                end else begin
                    m_run <= m_run + 1;
                end
            end else begin
                if (m_run != 0 && m_glitch != 255) m_glitch <= m_glitch + 1;
                m_run <= 0;
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        check("cyc_dout", 32'(dout), 32'(m_dout));
        check("cyc_rise", 32'(rise), 32'(m_rise));
        check("cyc_fall", 32'(fall), 32'(m_fall));
        check("cyc_busy", 32'(busy), 32'(m_run != 0));
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check("cyc_glitch", 32'(glitch_cnt), 32'(m_glitch));
`endif
    end

    task automatic drive(input logic v);
        @(negedge clk);
        din_raw = v;
    endtask

    // Record busy/rise/fall after each of the next 8 edges (bit i = edge E0+i)
    task automatic track(output logic [7:0] bv, output logic [7:0] rv, output logic [7:0] fv);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            bv[i] = busy;
            rv[i] = rise;
            fv[i] = fall;
        end
    endtask

    logic [7:0] bv, rv, fv;
    logic       any_rise;

    initial begin
        // 1: reset held with input high, then release
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_rise", 32'(rise), 32'd0);
        check("rst_fall", 32'(fall), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        track(bv, rv, fv);
        check("t1_rise_at6", 32'(rv), 32'h40);
        check("t1_busy", 32'(bv), 32'h3C);
        check("t1_dout", 32'(dout), 32'd1);

        // 4: release of the switch
        drive(1'b0);
        track(bv, rv, fv);
        check("t4_fall_at6", 32'(fv), 32'h40);
        check("t4_no_rise", 32'(rv), 32'h00);
        check("t4_busy", 32'(bv), 32'h3C);
        check("t4_dout", 32'(dout), 32'd0);

        // 2: clean press
        drive(1'b1);
        track(bv, rv, fv);
        check("t2_busy", 32'(bv), 32'h3C);
        check("t2_rise_at6", 32'(rv), 32'h40);
        check("t2_dout", 32'(dout), 32'd1);
        drive(1'b0);
        track(bv, rv, fv);
        check("t2_fall_at6", 32'(fv), 32'h40);

        // 3: bounce (3 high, 1 low, then steady high)
        any_rise = 1'b0;
        drive(1'b1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            any_rise |= rise;
        end
        drive(1'b0);
        @(posedge clk);
        #1;
        any_rise |= rise;
        drive(1'b1);
        track(bv, rv, fv);
        any_rise |= rv[5:0] != 6'd0;
        check("t3_no_early_rise", 32'(any_rise), 32'd0);
        check("t3_rise_at6", 32'(rv), 32'h40);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check("t3_glitch", 32'(glitch_cnt), 32'd1);
`endif
        drive(1'b0);
        track(bv, rv, fv);
        check("t3_fall", 32'(fv), 32'h40);

        // 5: reset in the middle of a qualification
        drive(1'b1);
        repeat (5) @(posedge clk);
        #1;
        check("t5_busy_pre", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check("t5_dout_async", 32'(dout), 32'd0);
        check("t5_busy_async", 32'(busy), 32'd0);
        check("t5_rise_async", 32'(rise), 32'd0);
        drive(1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        track(bv, rv, fv);
        check("t5_no_rise", 32'(rv), 32'h00);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check("t5_glitch_clr", 32'(glitch_cnt), 32'd0);

        // 6: glitch counter saturation
        any_rise = 1'b0;
        for (int g = 0; g < 300; g++) begin
            drive(1'b1);
            @(negedge clk);
            any_rise |= rise;
            drive(1'b0);
            any_rise |= rise;
            @(negedge clk);
            any_rise |= rise;
            @(negedge clk);
            any_rise |= rise;
        end
        repeat (4) @(negedge clk);
        check("t6_glitch_sat", 32'(glitch_cnt), 32'd255);
        check("t6_dout", 32'(dout), 32'd0);
        check("t6_no_rise", 32'(any_rise), 32'd0);
`endif

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/switch_debounce_sync.md
Name: switch_debounce_sync

Overview:
Conditions an asynchronous, bouncy input (push-button or switch) into a clean, clock-synchronous level for the D latch stage directly downstream; dout drives the latch data input. The block contains a 2-flop synchronizer, a counter-qualified 4-state FSM, and registered single-cycle edge pulses. Downstream logic can use rise and fall as event strobes.

Parameters:
CNT_W, 8, width of the stability counter.
STABLE_CYCLES, 200, number of consecutive synchronized cycles at the new level before dout changes; legal range 1..2**CNT_W, enforced by an elaboration-time check.

Ports:
clk  input  1  single clock; every flop is on its rising edge.
rst  input  1  asynchronous, active-low reset; assert with rst=0, release synchronously externally.
din_raw  input  1  raw asynchronous input.
dout  output  1  debounced level, registered.
rise  output  1  one-cycle pulse on a dout 0->1 change, registered.
fall  output  1  one-cycle pulse on a dout 1->0 change, registered.
busy  output  1  high while a candidate level change is being qualified.

Behaviour:
- Reset (rst=0, async): both sync flops=0, state=S_LOW, cnt=0, dout=0, rise=0, fall=0, busy=0.
- Synchronizer: s1<=din_raw; s2<=s1. Only s2 is used by the FSM.
- FSM states: S_LOW, S_LH, S_HIGH, S_HL; encoding comes from the package.
- S_LOW: if s2=1, go to S_LH with cnt<=0.
- S_LH: if s2=0, abort to S_LOW (glitch) with dout unchanged. Else if cnt==STABLE_CYCLES-1, go to S_HIGH with dout<=1 and rise<=1. Else cnt<=cnt+1.
- S_HIGH: if s2=0, go to S_HL with cnt<=0.
- S_HL: mirror of S_LH. s2=1 aborts to S_HIGH. At the terminal count, go to S_LOW with dout<=0 and fall<=1.
- rise and fall are 0 in every other cycle. They are never high together and never high for 2 consecutive cycles.
- busy is registered and equals (next state is S_LH or S_HL), so it is aligned with the state register.
- Latency: if din_raw is high at sampling edge E0 and stays high, dout=1 and rise=1 become visible after edge E0+STABLE_CYCLES+2.
- Counter never wraps: the terminal compare happens before increment. cnt is don't-care in S_LOW and S_HIGH and is held there.
- A bounce shorter than STABLE_CYCLES restarts qualification from cnt=0 on the next valid excursion.
- STABLE_CYCLES=1: a level change is qualified in exactly 1 cycle in S_LH/S_HL.
- Reset mid-qualification: immediate return to the reset values. A high din_raw held through reset release is re-qualified from S_LOW.

Optional Feature:
Macro DEBOUNCE_GLITCH_CNT_EN.
- Defined: adds output port glitch_cnt (output, 8 bits). It increments on every abort transition (S_LH->S_LOW or S_HL->S_HIGH), saturates at 255, and resets to 0.
- Undefined: the port and its logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package debounce_pkg holds the state typedef (2-bit enum S_LOW=0, S_LH=1, S_HIGH=2, S_HL=3) and the glitch counter width constant GLITCH_W=8.
- One sub-module, sync_2ff: 2-flop synchronizer with clk and rst (async active-low, reset value 0).
- FSM, counter and pulse registers live in the top module.

Test Plan (STABLE_CYCLES=4, CNT_W=8):
1. Reset: hold rst=0 with din_raw=1 for 3 cycles -> dout=0, rise=0, fall=0, busy=0. Release -> rise=1 exactly 6 edges after the first sampling edge post-release, then dout=1.
2. Clean press: din_raw 0->1 at E0 and held -> busy=1 from E0+2 to E0+5. dout=1 and rise=1 for exactly one cycle at E0+6.
3. Bounce: din_raw high for 3 cycles, low for 1, then high steady -> no rise during the bounce. rise occurs 6 edges after the final rising sample. With the macro defined, glitch_cnt=1.
4. Release: from dout=1, drive din_raw 1->0 and hold -> fall=1 for one cycle at E0+6, dout=0, rise stays 0.
5. Reset mid-qualification: assert rst=0 at E0+4 of a press -> dout=0 and busy=0 immediately (asynchronously), with no rise pulse.
6. Saturation (macro defined): 300 aborted 2-cycle glitches -> glitch_cnt=255 and held, dout stays 0.
